// File: rtl/rob_commit_ctrl_pkg.sv
// Shared constants and types for the reorder-buffer commit controller.
// Tag 0 is reserved as "no dependency"; a live entry's tag is its index plus one.
package rob_commit_ctrl_pkg;

    localparam int ROB_DEPTH_DEF = 16;
    localparam int TAG_W         = 5;
    localparam int REG_W         = 5;
    localparam int XLEN          = 32;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rob_state_e;

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Dispatch, writeback, commit and flush signals between the pipeline and the ROB.
// master = pipeline side, slave = the ROB itself.
interface rob_commit_ctrl_if;
    import rob_commit_ctrl_pkg::*;

    logic             alloc_valid;
    logic [REG_W-1:0] alloc_dest;
    logic             alloc_is_br;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;

    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [XLEN-1:0]  wb_data;
    logic             wb_mispredict;
    logic [XLEN-1:0]  wb_target;

    logic             commit_valid;
    logic [REG_W-1:0] commit_dest;
    logic [TAG_W-1:0] commit_tag;
    logic [XLEN-1:0]  commit_data;

    logic             flush;
    logic [XLEN-1:0]  flush_pc;

    modport master (
        output alloc_valid, alloc_dest, alloc_is_br,
        output wb_valid, wb_tag, wb_data, wb_mispredict, wb_target,
        input  alloc_ready, alloc_tag,
        input  commit_valid, commit_dest, commit_tag, commit_data,
        input  flush, flush_pc
    );

    modport slave (
        input  alloc_valid, alloc_dest, alloc_is_br,
        input  wb_valid, wb_tag, wb_data, wb_mispredict, wb_target,
        output alloc_ready, alloc_tag,
        output commit_valid, commit_dest, commit_tag, commit_data,
        output flush, flush_pc
    );

endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order retirement of out-of-order results; a mispredicted branch commits
// normally, then a one-cycle flush pulse empties the buffer and redirects the PC.
module rob_commit_ctrl
    import rob_commit_ctrl_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    rob_commit_ctrl_if.slave   bus
);

    localparam int PTR_W = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
    localparam int CNT_W = $clog2(ROB_DEPTH + 1);

    rob_state_e             state_reg;
    logic [PTR_W-1:0]       head_reg;
    logic [PTR_W-1:0]       tail_reg;
    logic [CNT_W-1:0]       count_reg;
    logic [ROB_DEPTH-1:0]   busy_reg;
    logic [ROB_DEPTH-1:0]   ready_reg;
    logic [XLEN-1:0]        saved_pc_reg;

    logic                   commit_valid_reg;
    logic [REG_W-1:0]       commit_dest_reg;
    logic [TAG_W-1:0]       commit_tag_reg;
    logic [XLEN-1:0]        commit_data_reg;
    logic                   flush_reg;
    logic [XLEN-1:0]        flush_pc_reg;

    logic [REG_W-1:0]       dest_mem   [ROB_DEPTH];
    logic                   is_br_mem  [ROB_DEPTH];
    logic                   misp_mem   [ROB_DEPTH];
    logic [XLEN-1:0]        data_mem   [ROB_DEPTH];
    logic [XLEN-1:0]        target_mem [ROB_DEPTH];

    logic                   alloc_ok;
    logic                   do_alloc;
    logic                   wb_in_range;
    logic [PTR_W-1:0]       wb_idx;
    logic                   wb_hit;
    logic                   do_retire;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ROB_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Space is judged from registered count only, so a same-cycle retire never frees a slot early.
    assign alloc_ok    = (state_reg == RUN) && (count_reg < CNT_W'(ROB_DEPTH));
    assign do_alloc    = rdy && bus.alloc_valid && alloc_ok;
    assign wb_in_range = (bus.wb_tag != TAG_NONE) && (bus.wb_tag <= TAG_W'(ROB_DEPTH));
    assign wb_idx      = PTR_W'(bus.wb_tag - TAG_W'(1));
    assign wb_hit      = rdy && (state_reg == RUN) && bus.wb_valid && wb_in_range && busy_reg[wb_idx];
    // Registered ready bit: a writeback landing this edge retires no earlier than the next.
    assign do_retire   = rdy && (state_reg == RUN) && (count_reg != '0) && ready_reg[head_reg];

    assign bus.alloc_ready  = alloc_ok;
    assign bus.alloc_tag    = TAG_W'(tail_reg) + TAG_W'(1);
    assign bus.commit_valid = commit_valid_reg;
    assign bus.commit_dest  = commit_dest_reg;
    assign bus.commit_tag   = commit_tag_reg;
    assign bus.commit_data  = commit_data_reg;
    assign bus.flush        = flush_reg;
    assign bus.flush_pc     = flush_pc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= RUN;
            head_reg         <= '0;
            tail_reg         <= '0;
            count_reg        <= '0;
            busy_reg         <= '0;
            ready_reg        <= '0;
            saved_pc_reg     <= '0;
            commit_valid_reg <= 1'b0;
            commit_dest_reg  <= '0;
            commit_tag_reg   <= '0;
            commit_data_reg  <= '0;
            flush_reg        <= 1'b0;
            flush_pc_reg     <= '0;
        end else if (rdy) begin
            commit_valid_reg <= 1'b0;
            flush_reg        <= 1'b0;
            case (state_reg)
                RUN: begin
                    if (do_alloc) begin
                        busy_reg[tail_reg]  <= 1'b1;
                        ready_reg[tail_reg] <= 1'b0;
                        tail_reg            <= ptr_inc(tail_reg);
                    end
                    if (wb_hit) begin
                        ready_reg[wb_idx] <= 1'b1;
                    end
                    if (do_retire) begin
                        busy_reg[head_reg]  <= 1'b0;
                        ready_reg[head_reg] <= 1'b0;
                        head_reg            <= ptr_inc(head_reg);
                        commit_valid_reg    <= 1'b1;
                        commit_dest_reg     <= dest_mem[head_reg];
                        commit_tag_reg      <= TAG_W'(head_reg) + TAG_W'(1);
                        commit_data_reg     <= data_mem[head_reg];
                        // Only branches can redirect; the link write above still lands.
                        if (misp_mem[head_reg] && is_br_mem[head_reg]) begin
                            saved_pc_reg <= target_mem[head_reg];
                            state_reg    <= FLUSH;
                        end
                    end
                    count_reg <= count_reg + CNT_W'(do_alloc) - CNT_W'(do_retire);
                end
                FLUSH: begin
                    flush_reg    <= 1'b1;
                    flush_pc_reg <= saved_pc_reg;
                    busy_reg     <= '0;
                    ready_reg    <= '0;
                    head_reg     <= '0;
                    tail_reg     <= '0;
                    count_reg    <= '0;
                    state_reg    <= RUN;
                end
                default: state_reg <= RUN;
            endcase
        end
    end

    // Payload needs no reset: it is only read behind the busy/ready bits.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            dest_mem[tail_reg]  <= bus.alloc_dest;
            is_br_mem[tail_reg] <= bus.alloc_is_br;
            misp_mem[tail_reg]  <= 1'b0;
        end
        if (wb_hit) begin
            data_mem[wb_idx]   <= bus.wb_data;
            misp_mem[wb_idx]   <= bus.wb_mispredict;
            target_mem[wb_idx] <= bus.wb_target;
        end
    end

endmodule

// File: doc/rob_commit_ctrl.md
ROB_COMMIT_CTRL -- requirements
Module: rob_commit_ctrl

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16, number of reorder entries; tag = index+1, so tag 0 always means "no dependency".
REQ-002 SHALL have ports clk  in  1  system clock; rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port rdy  in  1  global enable; when 0, all state and outputs hold.
REQ-004 SHALL have ports alloc_valid  in  1  dispatcher allocates an entry; alloc_dest  in  5  destination register; alloc_is_br  in  1  entry is a branch/jump.
REQ-005 SHALL have ports alloc_ready  out  1  entry available; alloc_tag  out  5  tag granted on this cycle's allocation.
REQ-006 SHALL have ports wb_valid  in  1  result broadcast; wb_tag  in  5  producing entry; wb_data  in  32  result; wb_mispredict  in  1  branch resolved wrong; wb_target  in  32  corrected PC.
REQ-007 SHALL have ports commit_valid  out  1  register-file write now; commit_dest  out  5  architectural register; commit_tag  out  5  committing tag, for stale-dependency check; commit_data  out  32  value.
REQ-008 SHALL have ports flush  out  1  mispredict recovery, clears register-file dependencies; flush_pc  out  32  redirect PC.

Function
REQ-009 SHALL store per entry: busy, ready, dest[4:0], is_br, mispredict, data[31:0], target[31:0]; head/tail pointers log2(ROB_DEPTH) bits wrapping ROB_DEPTH-1 to 0; count 0..ROB_DEPTH.
REQ-010 SHALL drive alloc_ready = (state==RUN) && (count < ROB_DEPTH), from registered state only; a commit in the same cycle does not free space for that cycle's allocation.
REQ-011 SHALL drive alloc_tag = tail+1 combinationally; on a clock edge with rdy && alloc_valid && alloc_ready, write the entry at tail as busy, not ready, and advance tail.
REQ-012 SHALL, on edge with rdy && wb_valid and entry wb_tag-1 busy, set ready and store data, mispredict, target; writebacks to tag 0 or to non-busy entries are ignored.
REQ-013 SHALL use FSM states RUN and FLUSH; reset enters RUN.
REQ-014 SHALL, in RUN, when count>0 and head entry ready, retire the head on the edge: register commit_valid=1, commit_dest, commit_tag=head+1, commit_data; clear busy; advance head; at most one retire per cycle.
REQ-015 SHALL register commit_valid=0 on any edge with no retire; a head of dest 0 still retires with commit_valid=1 and dest 0, which the register file ignores.
REQ-016 SHALL, when the retiring head has mispredict set, perform the normal commit (jalr/jal link writes land) and enter FLUSH on that edge.
REQ-017 SHALL, in FLUSH, assert flush=1 with flush_pc = saved target for exactly one cycle, clear all busy bits, and set head=tail=0, count=0; ignore alloc and wb; return to RUN on the next edge.
REQ-018 SHALL handle simultaneous alloc, writeback and retire in one edge with count' = count + alloc - retire.
REQ-019 SHALL accept writeback and retire of the same entry on one edge as writeback only; the retire follows on the next edge, giving wb-to-commit latency of 1 cycle minimum.
REQ-020 SHALL, when rdy=0, freeze every register including commit_valid and flush.

Reset
REQ-021 SHALL, on rst asserted asynchronously, clear all busy/ready bits, head, tail, count, state=RUN, commit_valid=0, commit_dest=0, commit_tag=0, commit_data=0, flush=0, flush_pc=0.
REQ-022 SHALL, after reset mid-operation, discard all in-flight entries; the first allocation after reset receives tag 1.

Structure
REQ-023 SHALL take ROB_DEPTH, tag width 5, the "no dependency" tag 0 and FSM state encodings from the shared const_def definitions.
REQ-024 SHALL be a single module with no sub-modules; entry storage is register arrays.

Verification
REQ-025 SHALL cover: reset, then allocate dest 5 to tag 1, wb tag 1 with data 0x1234 -> one cycle later commit_valid=1, dest 5, tag 1, data 0x1234.
REQ-026 SHALL cover: allocate 16 entries -> alloc_ready=0 after the 16th; retire one -> alloc_ready=1 the next cycle, and the 17th allocation receives tag 1 (wrap).
REQ-027 SHALL cover: out-of-order writeback to tags 3, 2, 1 -> commits in order 1, 2, 3 on consecutive cycles.
REQ-028 SHALL cover: branch tag 2 with wb_mispredict=1 and target 0x100, tags 3-4 allocated -> tag 2 commits, next cycle flush=1 and flush_pc=0x100, then count=0 and the next allocation receives tag 1.
REQ-029 SHALL cover: rdy=0 for 3 cycles with a ready head -> no retire and outputs frozen; rdy=1 -> retire resumes.
REQ-030 SHALL cover: rst asserted between clock edges while full -> all outputs 0 immediately, alloc_ready=1 after release.
